data_mem_responder: RTL and testbench

//  Word-addressed data memory with a valid/ready request/response interface. This is the

---
 rtl/data_mem_responder.sv | 136 +++++++++++++
 tb/tb_data_mem_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - word-addressed data memory responder for the CPU load/store port
//
// Purpose: services one valid/ready request at a time against a 32-bit word array `mem`,
//   with a programmable number of wait states before the response is presented.
// Ports:
//   clk        in   1       clock, rising edge
//   reset      in   1       asynchronous, active-low reset
//   req_valid  in   1       request present
//   req_ready  out  1       responder can accept a request
//   req_we     in   1       1 = store, 0 = load
//   req_addr   in   ADDR_W  byte address
//   req_wdata  in   32      store data
//   req_be     in   4       byte enables, bit i -> wdata[8i+7:8i]
//   rsp_valid  out  1       response present
//   rsp_ready  in   1       requester accepts response
//   rsp_rdata  out  32      load data (0 for stores and errors)
//   rsp_err    out  1       misaligned or out-of-range access

module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [3:0]        req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  logic [31:0] mem [DEPTH_WORDS];

  state_t            state;
  logic [3:0]        cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [3:0]        lat_be;

  logic [ADDR_W-3:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              acc_err;
  logic              commit;
  logic              do_write;

  assign word_idx = lat_addr[ADDR_W-1:2];
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign acc_err  = (lat_addr[1:0] != 2'b00) ||
                    (word_idx >= (ADDR_W-2)'(DEPTH_WORDS));

  // The access commits on the edge that moves WAIT -> RESP. The WAIT stage always
  // lasts WAIT_STATES+1 cycles so that a zero-wait-state access still answers one
  // cycle after accept.
  assign commit   = (state == S_WAIT) && (cnt == 4'd0);
  assign do_write = commit && lat_we && !acc_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
            cnt       <= 4'(WAIT_STATES);
            req_ready <= 1'b0;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= acc_err;
            rsp_rdata <= (!lat_we && !acc_err) ? mem[mem_idx] : 32'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          // rdata/err are left untouched here so they hold until the handshake
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Storage is deliberately not reset; an async reset forces state to IDLE, which
  // deasserts do_write before any uncommitted store can land.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_be[i]) begin
          mem[mem_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard testbench for data_mem_responder

module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic [2:0]  reset;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [2:0]  req_we;
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic [2:0]  rsp_valid;
  logic [2:0]  rsp_ready;
  logic [31:0] rsp_rdata [3];
  logic [2:0]  rsp_err;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    int          k;
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t exp_q[$];

  logic        seen     [3];
  logic [31:0] held_rd  [3];
  logic        held_err [3];
  int          hs_edge  [3];
  int          last_acc;

  // instance 0: WAIT_STATES=1, instance 1: WAIT_STATES=3, instance 2: WAIT_STATES=0
  data_mem_responder #(.DEPTH_WORDS(1024), .ADDR_W(32), .WAIT_STATES(1)) u_w1 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]));

  data_mem_responder #(.DEPTH_WORDS(1024), .ADDR_W(32), .WAIT_STATES(3)) u_w3 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]));

  data_mem_responder #(.DEPTH_WORDS(1024), .ADDR_W(32), .WAIT_STATES(0)) u_w0 (
    .clk(clk), .reset(reset[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int ws(input int k);
    return (k == 0) ? 1 : (k == 1) ? 3 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, where inputs and registered outputs are settled.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rsp_valid[k]) begin
        chk("req_ready_low_during_rsp", {31'd0, req_ready[k]}, 32'd0);
        if (!seen[k]) begin
          seen[k]     = 1'b1;
          held_rd[k]  = rsp_rdata[k];
          held_err[k] = rsp_err[k];
          if (exp_q.size() == 0 || exp_q[0].k != k) begin
            tests++;
            fails++;
            $display("FAIL unexpected_rsp: inst %0d got rdata %h expected no response", k, rsp_rdata[k]);
          end else begin
            chk("latency", cyc - exp_q[0].acc, 1 + ws(k));
          end
        end else begin
          chk("rdata_stable", rsp_rdata[k], held_rd[k]);
          chk("err_stable", {31'd0, rsp_err[k]}, {31'd0, held_err[k]});
        end
        if (rsp_ready[k]) begin
          seen[k]    = 1'b0;
          hs_edge[k] = cyc + 1;
          if (exp_q.size() != 0 && exp_q[0].k == k) begin
            chk("rsp_rdata", rsp_rdata[k], exp_q[0].rdata);
            chk("rsp_err", {31'd0, rsp_err[k]}, {31'd0, exp_q[0].err});
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic issue(input int k, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] er, input logic ee, input logic push);
    int t = 0;
    exp_t e;
    @(posedge clk); #2;
    req_we[k] = we; req_addr[k] = addr; req_wdata[k] = wdata; req_be[k] = be;
    req_valid[k] = 1'b1;
    while (!req_ready[k] && t < 50) begin
      @(posedge clk); #2;
      t++;
    end
    if (t >= 50) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: inst %0d req_ready stayed %b expected 1", k, req_ready[k]);
      req_valid[k] = 1'b0;
      return;
    end
    last_acc = cyc + 1;
    if (push) begin
      e.k = k; e.rdata = er; e.err = ee; e.acc = last_acc;
      exp_q.push_back(e);
    end
    @(posedge clk); #2;
    // Scramble request fields after accept; the latched copy must be used.
    req_valid[k] = 1'b0;
    req_we[k] = ~we; req_addr[k] = 32'hFFFF_FFF3; req_wdata[k] = 32'hDEAD_BEEF; req_be[k] = 4'hF;
  endtask

  task automatic wait_done(input int k);
    int t = 0;
    while ((exp_q.size() != 0 || rsp_valid[k]) && t < 100) begin
      @(posedge clk); #2;
      t++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time %0t expected finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 3'b000;
    req_valid = 3'b000; req_we = 3'b000; rsp_ready = 3'b111;
    for (int k = 0; k < 3; k++) begin
      req_addr[k] = 32'd0; req_wdata[k] = 32'd0; req_be[k] = 4'd0;
      seen[k] = 1'b0; hs_edge[k] = 0;
    end
    repeat (3) @(posedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      chk("reset_req_ready", {31'd0, req_ready[k]}, 32'd1);
      chk("reset_rsp_valid", {31'd0, rsp_valid[k]}, 32'd0);
      chk("reset_rsp_rdata", rsp_rdata[k], 32'd0);
      chk("reset_rsp_err", {31'd0, rsp_err[k]}, 32'd0);
    end
    reset = 3'b111;

    u_w1.mem[0] = 32'h5555_5554;
    u_w1.mem[3] = 32'hAABB_CCDD;
    u_w3.mem[1] = 32'hCAFE_F00D;
    u_w0.mem[0] = 32'h0BAD_F00D;
    u_w0.mem[1] = 32'h1357_9BDF;

    // 1: load with one wait state
    issue(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h5555_5554, 1'b0, 1'b1);
    wait_done(0);

    // 2: partial store then load back
    issue(0, 1'b1, 32'd12, 32'h1122_3344, 4'b0011, 32'h0, 1'b0, 1'b1);
    wait_done(0);
    issue(0, 1'b0, 32'd12, 32'h0, 4'h0, 32'hAABB_3344, 1'b0, 1'b1);
    wait_done(0);

    // 3: errors and a byte-enable-free store
    issue(0, 1'b0, 32'h6, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
    wait_done(0);
    issue(0, 1'b1, 32'd4096, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1, 1'b1);
    wait_done(0);
    issue(0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, 1'b1);
    wait_done(0);
    chk("mem0_untouched", u_w1.mem[0], 32'h5555_5554);
    chk("mem3_untouched", u_w1.mem[3], 32'hAABB_3344);

    // 4: backpressure for three cycles
    rsp_ready[0] = 1'b0;
    issue(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h5555_5554, 1'b0, 1'b1);
    begin
      int t = 0;
      while (!rsp_valid[0] && t < 20) begin
        @(posedge clk); #2;
        t++;
      end
      chk("bp_rsp_seen", {31'd0, rsp_valid[0]}, 32'd1);
    end
    repeat (3) begin
      @(posedge clk); #2;
      chk("bp_held_valid", {31'd0, rsp_valid[0]}, 32'd1);
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #2;
    chk("bp_ready_after", {31'd0, req_ready[0]}, 32'd1);
    chk("bp_valid_after", {31'd0, rsp_valid[0]}, 32'd0);
    wait_done(0);

    // 5: reset during the second wait cycle drops the store
    issue(1, 1'b1, 32'd4, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #2;
    reset[1] = 1'b0;
    #1;
    chk("rst_req_ready", {31'd0, req_ready[1]}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid[1]}, 32'd0);
    repeat (5) @(posedge clk);
    #2;
    reset[1] = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    chk("rst_mem1", u_w3.mem[1], 32'hCAFE_F00D);
    chk("rst_no_rsp", {31'd0, rsp_valid[1]}, 32'd0);

    // 6: zero wait states, back-to-back loads
    issue(2, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0, 1'b1);
    issue(2, 1'b0, 32'h4, 32'h0, 4'h0, 32'h1357_9BDF, 1'b0, 1'b1);
    chk("b2b_accept_gap", last_acc - hs_edge[2], 1);
    wait_done(2);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
